// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared constants and types for the instruction fetch memory
package inst_fetch_pkg;

    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

    localparam int FAULT_MISALIGN = 0;
    localparam int FAULT_RANGE    = 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/inst_byte_ram.sv
// rtl/inst_byte_ram.sv - byte-writable program RAM with a combinational 32-bit word read
module inst_byte_ram #(
    parameter  int DEPTH_BYTES = 256,
    localparam int AW          = $clog2(DEPTH_BYTES),
    localparam int WORDS       = DEPTH_BYTES / 4,
    localparam int WI          = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [WI-1:0] rindex,
    output logic [31:0]   rdata
);

    // Word-organised storage so the read is one indexed access; byte lane picks the write target.
    logic [3:0][7:0] mem [WORDS];

    logic [WI-1:0] windex;
    assign windex = WI'(waddr >> 2);

    always_ff @(posedge clk) begin
        if (we) begin
            mem[windex][waddr[1:0]] <= wdata;
        end
    end

    assign rdata = mem[rindex];

endmodule

// File: rtl/inst_fetch_mem.sv
// rtl/inst_fetch_mem.sv - registered-read instruction memory with handshake, fault checks and load port
module inst_fetch_mem
    import inst_fetch_pkg::*;
#(
    parameter int          DEPTH_BYTES = 256,
    parameter int          ADDR_W      = 64,
    parameter logic [31:0] NOP_INST    = NOP_INST_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Req_Valid,
    output logic              Req_Ready,
    input  logic [ADDR_W-1:0] Inst_Address,
    output logic              Rsp_Valid,
    input  logic              Rsp_Ready,
    output logic [31:0]       Instruction,
    output logic [1:0]        Fault,
    input  logic              Flush,
    input  logic              Load_En,
    input  logic [ADDR_W-1:0] Load_Address,
    input  logic [7:0]        Load_Data,
    output logic [31:0]       Fetch_Count
);

    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int WI    = (WORDS > 1) ? $clog2(WORDS) : 1;

    fetch_state_t state;

    logic              accept;
    logic              load_in_range;
    logic [ADDR_W:0]   fetch_last_byte;
    logic [1:0]        fetch_fault;
    logic [WI-1:0]     read_index;
    logic [31:0]       ram_word;
    logic [31:0]       next_instruction;

    // One extra bit keeps a+3 from wrapping near the top of the address space.
    assign fetch_last_byte = {1'b0, Inst_Address} + (ADDR_W+1)'(3);

    always_comb begin
        fetch_fault                 = '0;
        fetch_fault[FAULT_MISALIGN] = |Inst_Address[1:0];
        fetch_fault[FAULT_RANGE]    = fetch_last_byte >= (ADDR_W+1)'(DEPTH_BYTES);
    end

    assign load_in_range = Load_Address < ADDR_W'(DEPTH_BYTES);
    assign read_index    = WI'(Inst_Address[AW-1:0] >> 2);

    inst_byte_ram #(
        .DEPTH_BYTES (DEPTH_BYTES)
    ) u_ram (
        .clk    (clk),
        .we     (Load_En && load_in_range),
        .waddr  (Load_Address[AW-1:0]),
        .wdata  (Load_Data),
        .rindex (read_index),
        .rdata  (ram_word)
    );

    assign next_instruction = (|fetch_fault) ? NOP_INST : ram_word;

    assign Req_Ready = !reset && !Load_En && !Flush && (state == EMPTY || Rsp_Ready);
    assign accept    = Req_Valid && Req_Ready;
    assign Rsp_Valid = (state == FULL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= EMPTY;
            Instruction <= '0;
            Fault       <= '0;
            Fetch_Count <= '0;
        end else if (Flush) begin
            state <= EMPTY;
        end else if (accept) begin
            state       <= FULL;
            Instruction <= next_instruction;
            Fault       <= fetch_fault;
            Fetch_Count <= Fetch_Count + 32'd1;
        end else if (state == FULL && Rsp_Ready) begin
            state <= EMPTY;
        end
    end

endmodule

// File: tb/tb_inst_fetch_mem.sv
// tb/tb_inst_fetch_mem.sv - directed vector bench for inst_fetch_mem
module tb_inst_fetch_mem;

    localparam int          DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        Req_Valid;
    logic        Req_Ready;
    logic [63:0] Inst_Address;
    logic        Rsp_Valid;
    logic        Rsp_Ready;
    logic [31:0] Instruction;
    logic [1:0]  Fault;
    logic        Flush;
    logic        Load_En;
    logic [63:0] Load_Address;
    logic [7:0]  Load_Data;
    logic [31:0] Fetch_Count;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_count = 0;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] inst;
        logic [1:0]  fault;
    } vec_t;

    vec_t vecs[10];

    inst_fetch_mem #(
        .DEPTH_BYTES (DEPTH),
        .ADDR_W      (64),
        .NOP_INST    (NOP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Req_Valid    (Req_Valid),
        .Req_Ready    (Req_Ready),
        .Inst_Address (Inst_Address),
        .Rsp_Valid    (Rsp_Valid),
        .Rsp_Ready    (Rsp_Ready),
        .Instruction  (Instruction),
        .Fault        (Fault),
        .Flush        (Flush),
        .Load_En      (Load_En),
        .Load_Address (Load_Address),
        .Load_Data    (Load_Data),
        .Fetch_Count  (Fetch_Count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic load_byte(input logic [63:0] a, input logic [7:0] d);
        @(negedge clk);
        Load_En      = 1'b1;
        Load_Address = a;
        Load_Data    = d;
        @(posedge clk);
        #1;
        Load_En = 1'b0;
    endtask

    task automatic load_word(input logic [63:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            load_byte(a + 64'(i), w[8*i +: 8]);
        end
    endtask

    // Single fetch from EMPTY with the consumer always ready.
    task automatic fetch_one(input string tag, input logic [63:0] a,
                             input logic [31:0] inst, input logic [1:0] fault);
        @(negedge clk);
        Req_Valid    = 1'b1;
        Inst_Address = a;
        Rsp_Ready    = 1'b1;
        #1;
        check({tag, " req_ready"}, 64'(Req_Ready), 64'd1);
        @(posedge clk);
        #1;
        Req_Valid = 1'b0;
        exp_count++;
        check({tag, " rsp_valid"}, 64'(Rsp_Valid), 64'd1);
        check({tag, " instruction"}, 64'(Instruction), 64'(inst));
        check({tag, " fault"}, 64'(Fault), 64'(fault));
        check({tag, " fetch_count"}, 64'(Fetch_Count), 64'(exp_count));
        @(posedge clk);
        #1;
        check({tag, " drained"}, 64'(Rsp_Valid), 64'd0);
    endtask

    initial begin
        vecs[0] = '{64'h0,            32'h0010_0313, 2'b00};
        vecs[1] = '{64'h4,            32'h0050_0093, 2'b00};
        vecs[2] = '{64'h8,            32'h0020_8133, 2'b00};
        vecs[3] = '{64'(DEPTH - 4),   32'hDEAD_BEEF, 2'b00};
        vecs[4] = '{64'h2,            NOP,           2'b01};
        vecs[5] = '{64'(DEPTH - 2),   NOP,           2'b11};
        vecs[6] = '{64'(DEPTH - 3),   NOP,           2'b11};
        vecs[7] = '{64'h1_0000_0000,  NOP,           2'b10};
        vecs[8] = '{64'h1_0000_0004,  NOP,           2'b10};
        vecs[9] = '{64'(DEPTH),       NOP,           2'b10};

        reset        = 1'b1;
        Req_Valid    = 1'b0;
        Inst_Address = '0;
        Rsp_Ready    = 1'b0;
        Flush        = 1'b0;
        Load_En      = 1'b0;
        Load_Address = '0;
        Load_Data    = '0;

        #2;
        check("reset req_ready", 64'(Req_Ready), 64'd0);
        check("reset rsp_valid", 64'(Rsp_Valid), 64'd0);
        check("reset instruction", 64'(Instruction), 64'd0);
        check("reset fault", 64'(Fault), 64'd0);
        check("reset fetch_count", 64'(Fetch_Count), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        load_word(64'h0, 32'h0010_0313);
        load_word(64'h4, 32'h0050_0093);
        load_word(64'h8, 32'h0020_8133);
        load_word(64'(DEPTH - 4), 32'hDEAD_BEEF);
        // Out-of-range writes must not alias onto low bytes.
        load_byte(64'(DEPTH), 8'hAA);
        load_byte(64'h1_0000_0001, 8'hAA);

        for (int i = 0; i < 10; i++) begin
            fetch_one($sformatf("vec%0d", i), vecs[i].addr, vecs[i].inst, vecs[i].fault);
        end

        // Back-to-back fetches of 0, 4, 8.
        @(negedge clk);
        Req_Valid    = 1'b1;
        Inst_Address = 64'h0;
        Rsp_Ready    = 1'b1;
        @(posedge clk);
        #1;
        exp_count++;
        check("b2b0 instruction", 64'(Instruction), 64'h0010_0313);
        check("b2b0 req_ready", 64'(Req_Ready), 64'd1);
        Inst_Address = 64'h4;
        @(posedge clk);
        #1;
        exp_count++;
        check("b2b1 rsp_valid", 64'(Rsp_Valid), 64'd1);
        check("b2b1 instruction", 64'(Instruction), 64'h0050_0093);
        check("b2b1 req_ready", 64'(Req_Ready), 64'd1);
        Inst_Address = 64'h8;
        @(posedge clk);
        #1;
        exp_count++;
        Req_Valid = 1'b0;
        check("b2b2 instruction", 64'(Instruction), 64'h0020_8133);
        check("b2b fetch_count", 64'(Fetch_Count), 64'(exp_count));
        @(posedge clk);
        #1;
        check("b2b drained", 64'(Rsp_Valid), 64'd0);

        // Stalled response held bit-stable while byte 4 is rewritten.
        @(negedge clk);
        Req_Valid    = 1'b1;
        Inst_Address = 64'h4;
        Rsp_Ready    = 1'b0;
        @(posedge clk);
        #1;
        exp_count++;
        check("stall instruction", 64'(Instruction), 64'h0050_0093);
        Inst_Address = 64'h8;
        Load_En      = 1'b1;
        Load_Address = 64'h4;
        Load_Data    = 8'h77;
        @(posedge clk);
        #1;
        Load_En = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("stall held inst", 64'(Instruction), 64'h0050_0093);
            check("stall req_ready", 64'(Req_Ready), 64'd0);
            check("stall rsp_valid", 64'(Rsp_Valid), 64'd1);
            check("stall fetch_count", 64'(Fetch_Count), 64'(exp_count));
            @(posedge clk);
            #1;
        end
        Rsp_Ready = 1'b1;
        #1;
        check("stall release req_ready", 64'(Req_Ready), 64'd1);
        @(posedge clk);
        #1;
        exp_count++;
        Req_Valid = 1'b0;
        check("stall next instruction", 64'(Instruction), 64'h0020_8133);
        check("stall next fetch_count", 64'(Fetch_Count), 64'(exp_count));
        @(posedge clk);
        #1;
        check("stall drained", 64'(Rsp_Valid), 64'd0);
        fetch_one("rewritten", 64'h4, 32'h0050_0077, 2'b00);

        // Flush drops a held response and blocks a concurrent request.
        @(negedge clk);
        Req_Valid    = 1'b1;
        Inst_Address = 64'h0;
        Rsp_Ready    = 1'b0;
        @(posedge clk);
        #1;
        exp_count++;
        Inst_Address = 64'h4;
        Flush        = 1'b1;
        #1;
        check("flush req_ready", 64'(Req_Ready), 64'd0);
        @(posedge clk);
        #1;
        Flush     = 1'b0;
        Req_Valid = 1'b0;
        check("flush rsp_valid", 64'(Rsp_Valid), 64'd0);
        check("flush fetch_count", 64'(Fetch_Count), 64'(exp_count));

        // Load and request together: load wins.
        @(negedge clk);
        Load_En      = 1'b1;
        Load_Address = 64'd12;
        Load_Data    = 8'h55;
        Req_Valid    = 1'b1;
        Inst_Address = 64'h0;
        Rsp_Ready    = 1'b1;
        #1;
        check("load+req req_ready", 64'(Req_Ready), 64'd0);
        @(posedge clk);
        #1;
        Load_En   = 1'b0;
        Req_Valid = 1'b0;
        check("load+req rsp_valid", 64'(Rsp_Valid), 64'd0);
        check("load+req fetch_count", 64'(Fetch_Count), 64'(exp_count));
        load_byte(64'd13, 8'h00);
        load_byte(64'd14, 8'h00);
        load_byte(64'd15, 8'h00);
        fetch_one("loaded12", 64'd12, 32'h0000_0055, 2'b00);

        // Asynchronous reset in the middle of a held response.
        @(negedge clk);
        Req_Valid    = 1'b1;
        Inst_Address = 64'h0;
        Rsp_Ready    = 1'b0;
        @(posedge clk);
        #1;
        Req_Valid = 1'b0;
        exp_count++;
        check("pre-reset rsp_valid", 64'(Rsp_Valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async reset rsp_valid", 64'(Rsp_Valid), 64'd0);
        check("async reset fetch_count", 64'(Fetch_Count), 64'd0);
        check("async reset instruction", 64'(Instruction), 64'd0);
        check("async reset req_ready", 64'(Req_Ready), 64'd0);
        exp_count = 0;
        @(negedge clk);
        reset = 1'b0;
        fetch_one("post-reset", 64'h0, 32'h0010_0313, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
